// File: rtl/sram_boot_ctr.sv
// Boot loader in front of the SRAM instruction port: takes a length-prefixed byte image,
// packs it into words written from address 0, then releases the CPU and becomes a passthrough.
module sram_boot_ctr #(
   parameter int SRAM_ADDR_W = 15,
   parameter int DATA_W      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic [7:0]               s_data,
   output logic                     s_ready,
   input  logic                     cpu_i_valid,
   input  logic [SRAM_ADDR_W-3:0]   cpu_i_addr,
   output logic [DATA_W-1:0]        cpu_i_rdata,
   output logic                     cpu_i_ready,
   output logic                     sram_i_valid,
   output logic [SRAM_ADDR_W-3:0]   sram_i_addr,
   output logic [DATA_W-1:0]        sram_i_wdata,
   output logic [DATA_W/8-1:0]      sram_i_wstrb,
   input  logic [DATA_W-1:0]        sram_i_rdata,
   input  logic                     sram_i_ready,
   output logic                     cpu_rst,
   output logic                     boot_done,
   output logic                     boot_err
);

   localparam int          WA_W    = SRAM_ADDR_W - 2;
   localparam logic [32:0] MAX_LEN = 33'd1 << SRAM_ADDR_W;

   typedef enum logic [2:0] {
      S_HDR,
      S_LOAD,
      S_WR,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              hdr_cnt_q, hdr_cnt_d;
   logic [31:0]             len_q, len_d;
   logic [31:0]             byte_cnt_q, byte_cnt_d;
   logic [WA_W-1:0]         word_addr_q, word_addr_d;
   logic [DATA_W-1:0]       buf_q, buf_d;
   logic [DATA_W/8-1:0]     strb_q, strb_d;

   logic [31:0]             hdr_len;
   logic [1:0]              lane;

   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      word_addr_d = word_addr_q;
      buf_d       = buf_q;
      strb_d      = strb_q;
      hdr_len     = len_q;
      lane        = byte_cnt_q[1:0];

      case (state_q)
         S_HDR: begin
            if (s_valid) begin
               hdr_len[8*hdr_cnt_q +: 8] = s_data;
               len_d     = hdr_len;
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               if (hdr_cnt_q == 2'd3) begin
                  byte_cnt_d  = 32'd0;
                  word_addr_d = '0;
                  buf_d       = '0;
                  strb_d      = '0;
                  if (hdr_len == 32'd0) begin
                     state_d = S_DONE;
                  end else if ({1'b0, hdr_len} > MAX_LEN) begin
                     state_d = S_ERR;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end
         S_LOAD: begin
            if (s_valid) begin
               buf_d[8*lane +: 8] = s_data;
               strb_d[lane]       = 1'b1;
               byte_cnt_d         = byte_cnt_q + 32'd1;
               // A short final word is flushed as soon as its last byte lands.
               if (lane == 2'd3 || byte_cnt_d == len_q) begin
                  state_d = S_WR;
               end
            end
         end
         S_WR: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sram_i_ready) begin
               word_addr_d = word_addr_q + WA_W'(1);
               buf_d       = '0;
               strb_d      = '0;
               state_d     = (byte_cnt_q == len_q) ? S_DONE : S_LOAD;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HDR;
         hdr_cnt_q   <= 2'd0;
         len_q       <= 32'd0;
         byte_cnt_q  <= 32'd0;
         word_addr_q <= '0;
         buf_q       <= '0;
         strb_q      <= '0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         word_addr_q <= word_addr_d;
         buf_q       <= buf_d;
         strb_q      <= strb_d;
      end
   end

   // Everything below decodes registered state; only the DONE passthrough is combinational.
   assign s_ready      = (state_q == S_HDR) || (state_q == S_LOAD);
   assign cpu_rst      = (state_q != S_DONE);
   assign boot_done    = (state_q == S_DONE);
   assign boot_err     = (state_q == S_ERR);

   assign sram_i_valid = (state_q == S_WR) ? 1'b1 :
                         (state_q == S_DONE) ? cpu_i_valid : 1'b0;
   assign sram_i_addr  = (state_q == S_WR) ? word_addr_q :
                         (state_q == S_DONE) ? cpu_i_addr : '0;
   assign sram_i_wdata = (state_q == S_WR) ? buf_q : '0;
   assign sram_i_wstrb = (state_q == S_WR) ? strb_q : '0;

   assign cpu_i_rdata  = (state_q == S_DONE) ? sram_i_rdata : '0;
   assign cpu_i_ready  = (state_q == S_DONE) && sram_i_ready;

endmodule

// File: tb/tb_sram_boot_ctr.sv
// Bench for sram_boot_ctr: byte driver, SRAM model with one-cycle ready, write scoreboard.
module tb_sram_boot_ctr;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        cpu_i_valid;
   logic [12:0] cpu_i_addr;
   logic [31:0] cpu_i_rdata;
   logic        cpu_i_ready;
   logic        sram_i_valid;
   logic [12:0] sram_i_addr;
   logic [31:0] sram_i_wdata;
   logic [3:0]  sram_i_wstrb;
   logic [31:0] sram_i_rdata;
   logic        sram_i_ready;
   logic        cpu_rst;
   logic        boot_done;
   logic        boot_err;

   sram_boot_ctr #(.SRAM_ADDR_W(15), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .cpu_i_valid  (cpu_i_valid),
      .cpu_i_addr   (cpu_i_addr),
      .cpu_i_rdata  (cpu_i_rdata),
      .cpu_i_ready  (cpu_i_ready),
      .sram_i_valid (sram_i_valid),
      .sram_i_addr  (sram_i_addr),
      .sram_i_wdata (sram_i_wdata),
      .sram_i_wstrb (sram_i_wstrb),
      .sram_i_rdata (sram_i_rdata),
      .sram_i_ready (sram_i_ready),
      .cpu_rst      (cpu_rst),
      .boot_done    (boot_done),
      .boot_err     (boot_err)
   );

   typedef struct {
      logic [12:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  img[$];
   logic [31:0] mem [0:8191];
   int          n_chk = 0;
   int          n_err = 0;
   int          wr_count = 0;
   bit          pend_v = 0;
   logic [12:0] pend_a = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // SRAM model: requests sampled mid-cycle, ready/rdata returned on the next edge.
   always @(negedge clk) begin
      wr_t e;
      pend_v = sram_i_valid;
      pend_a = sram_i_addr;
      if (sram_i_valid && sram_i_wstrb != 4'd0) begin
         wr_count++;
         for (int l = 0; l < 4; l++)
            if (sram_i_wstrb[l]) mem[sram_i_addr][8*l +: 8] = sram_i_wdata[8*l +: 8];
         if (exp_q.size() == 0) begin
            chk("unexp_wr", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {19'd0, sram_i_addr}, {19'd0, e.a});
            chk("wr_data", sram_i_wdata, e.d);
            chk("wr_strb", {28'd0, sram_i_wstrb}, {28'd0, e.s});
         end
      end
   end

   always @(posedge clk) begin
      sram_i_ready <= pend_v;
      sram_i_rdata <= mem[pend_a];
   end

   task automatic chk_reset_vals();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_boot_done", boot_done, 0);
      chk("rst_boot_err", boot_err, 0);
      chk("rst_sram_valid", sram_i_valid, 0);
      chk("rst_sram_addr", sram_i_addr, 0);
      chk("rst_sram_wdata", sram_i_wdata, 0);
      chk("rst_sram_wstrb", sram_i_wstrb, 0);
      chk("rst_cpu_ready", cpu_i_ready, 0);
      chk("rst_cpu_rdata", cpu_i_rdata, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int n;
      n = 0;
      if (stall) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            s_valid = 1'b0;
         end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("s_ready_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] len, input bit stall);
      logic [31:0] l;
      l = len;
      for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], stall);
   endtask

   // Pushes the expected word writes for img[], then streams header and image.
   task automatic load_image(input bit stall);
      wr_t w;
      int  len;
      len = img.size();
      w.d = '0;
      w.s = '0;
      for (int k = 0; k < len; k++) begin
         w.d[8*(k%4) +: 8] = img[k];
         w.s[k%4]          = 1'b1;
         if (k % 4 == 3 || k == len - 1) begin
            w.a = 13'(k / 4);
            exp_q.push_back(w);
            w.d = '0;
            w.s = '0;
         end
      end
      send_hdr(32'(len), stall);
      for (int k = 0; k < len; k++) send_byte(img[k], stall);
      idle();
   endtask

   task automatic wait_done(input int target);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (n < 60000 && !seen) begin
         @(negedge clk);
         #1;
         if (wr_count == target && sram_i_ready) seen = 1;
         n++;
      end
      chk("last_ready_seen", seen, 1);
      chk("cpu_rst_at_last_ready", cpu_rst, 1);
      @(negedge clk);
      #1;
      chk("cpu_rst_after_done", cpu_rst, 0);
      chk("boot_done", boot_done, 1);
      chk("s_ready_done", s_ready, 0);
      chk("exp_q_empty", exp_q.size(), 0);
   endtask

   int base;

   initial begin
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = 8'd0;
      cpu_i_valid = 1'b0;
      cpu_i_addr = '0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b0;

      // 8-byte image, two full words
      base = wr_count;
      img = {};
      for (int i = 0; i < 8; i++) img.push_back(8'h11 + 8'(i));
      load_image(0);
      wait_done(base + 2);

      // passthrough read of word 1
      @(posedge clk);
      #1;
      cpu_i_valid = 1'b1;
      cpu_i_addr  = 13'd1;
      @(negedge clk);
      #1;
      chk("pt_sram_valid", sram_i_valid, 1);
      chk("pt_sram_addr", sram_i_addr, 1);
      chk("pt_sram_wstrb", sram_i_wstrb, 0);
      chk("pt_sram_wdata", sram_i_wdata, 0);
      @(posedge clk);
      #1;
      cpu_i_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("pt_cpu_ready", cpu_i_ready, 1);
      chk("pt_cpu_rdata", cpu_i_rdata, 32'h18171615);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h55;
      #1;
      chk("extra_byte_s_ready", s_ready, 0);
      repeat (3) @(negedge clk);
      chk("extra_byte_still_done", boot_done, 1);
      s_valid = 1'b0;

      // 5-byte image, partial last word
      do_reset();
      base = wr_count;
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      load_image(0);
      wait_done(base + 2);

      // same 8-byte image with random s_valid stalls
      do_reset();
      base = wr_count;
      img = {};
      for (int i = 0; i < 8; i++) img.push_back(8'h11 + 8'(i));
      load_image(1);
      wait_done(base + 2);

      // L == 0 goes straight to DONE
      do_reset();
      base = wr_count;
      send_hdr(32'd0, 1);
      idle();
      #1;
      chk("l0_boot_done", boot_done, 1);
      chk("l0_cpu_rst", cpu_rst, 0);
      repeat (4) @(negedge clk);
      chk("l0_no_writes", wr_count, base);

      // L == 2^15 fills memory exactly
      do_reset();
      base = wr_count;
      img = {};
      for (int k = 0; k < 32768; k++) img.push_back(8'(k) ^ 8'(k >> 8));
      load_image(0);
      wait_done(base + 8192);
      chk("full_last_word", mem[8191], {img[32767], img[32766], img[32765], img[32764]});

      // L == 2^15 + 1 is rejected
      do_reset();
      send_hdr(32'h0000_8001, 0);
      idle();
      #1;
      chk("err_boot_err", boot_err, 1);
      chk("err_s_ready", s_ready, 0);
      chk("err_cpu_rst", cpu_rst, 1);
      chk("err_boot_done", boot_done, 0);

      // reset during WAIT of word 3, then reboot with one word
      do_reset();
      base = wr_count;
      img = {};
      for (int i = 0; i < 16; i++) img.push_back(8'h40 + 8'(i));
      load_image(0);
      begin
         int n;
         n = 0;
         while (wr_count != base + 4 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
         end
         chk("word3_written", wr_count, base + 4);
      end
      rst = 1'b1;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      base = wr_count;
      img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      load_image(0);
      wait_done(base + 1);
      chk("reboot_word0", mem[0], 32'hA4A3A2A1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/sram_boot_ctr.md
# sram_boot_ctr

Boot controller sitting directly upstream of the main SRAM instruction port.
- Out of reset it holds the CPU in reset and accepts a byte stream (from the UART or boot ROM reader): a 4-byte length header, then the program image.
- It packs the image into 32-bit words, writes them into SRAM from address 0 through the SRAM instruction port, then releases the CPU.
- After boot it passes the CPU instruction bus through to SRAM unchanged.

## Interface
Parameters:
- SRAM_ADDR_W, 15, SRAM byte-address width; word address width is SRAM_ADDR_W-2.
- DATA_W, 32, word width; only 32 is supported.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  boot byte valid.
- s_data  in  8  boot byte.
- s_ready  out  1  byte accepted when s_valid && s_ready at a rising clk edge.
- cpu_i_valid  in  1  CPU instruction request.
- cpu_i_addr  in  SRAM_ADDR_W-2  CPU instruction word address.
- cpu_i_rdata  out  DATA_W  instruction data to CPU.
- cpu_i_ready  out  1  instruction ready to CPU.
- sram_i_valid  out  1  SRAM instruction-port enable.
- sram_i_addr  out  SRAM_ADDR_W-2  SRAM word address.
- sram_i_wdata  out  DATA_W  SRAM write data.
- sram_i_wstrb  out  DATA_W/8  SRAM byte write enables.
- sram_i_rdata  in  DATA_W  SRAM read data.
- sram_i_ready  in  1  SRAM ready; asserted exactly one cycle after sram_i_valid.
- cpu_rst  out  1  CPU reset, active-high.
- boot_done  out  1  image loaded, CPU running.
- boot_err  out  1  header length exceeds SRAM size.

## Operation
- States: HDR, LOAD, WR, WAIT, DONE, ERR. Reset state is HDR.

HDR
- s_ready=1. Collects 4 bytes, little-endian, into 32-bit length L (bytes).
- After the 4th byte:
  - L==0 goes to DONE.
  - L > 2^SRAM_ADDR_W goes to ERR.
  - Otherwise goes to LOAD with byte count 0 and word address 0.

LOAD
- s_ready=1. Byte k of the payload goes to lane k%4 of word buffer bits [8*(k%4)+7 : 8*(k%4)], and its strobe bit is set.
- Transitions to WR when 4 bytes are buffered, or when byte L-1 is accepted (partial last word).

WR
- One cycle: sram_i_valid=1, sram_i_addr=word count, sram_i_wdata=buffer, sram_i_wstrb=buffered lanes.
- Unfilled lanes have strobe 0 and data 0.
- s_ready=0. Next state is WAIT.

WAIT
- s_ready=0, sram_i_valid=0. On sram_i_ready:
  - increment word address;
  - clear buffer and strobes;
  - go to DONE if all L bytes are written, else back to LOAD.

DONE
- cpu_rst=0, boot_done=1, s_ready=0; extra bytes are not consumed.
- Passthrough:
  - sram_i_valid=cpu_i_valid and sram_i_addr=cpu_i_addr;
  - sram_i_wstrb=0 and sram_i_wdata=0;
  - cpu_i_rdata=sram_i_rdata and cpu_i_ready=sram_i_ready.
- Terminal until rst.

ERR
- boot_err=1, cpu_rst=1, s_ready=0. Terminal until rst.

While not in DONE
- cpu_i_ready=0 and cpu_i_rdata=0.
- cpu_i_valid is ignored; it is never forwarded.

Arithmetic
- Length and byte counters are 32-bit.
- Word address is SRAM_ADDR_W-2 bits. L == 2^SRAM_ADDR_W is legal and fills memory exactly; the address does not wrap before the final write.

## Timing
- Reset values (asynchronous, immediate):
  - state HDR;
  - cpu_rst=1, boot_done=0, boot_err=0;
  - sram_i_valid=0, sram_i_wstrb=0, sram_i_addr=0, sram_i_wdata=0;
  - cpu_i_ready=0;
  - s_ready=1, decoded from state HDR.
- s_ready, the sram_i_* outputs in WR, cpu_rst, boot_done and boot_err are decoded from registered state (no combinational path from s_valid).
- Exception: in DONE the passthrough paths are combinational.
- Throughput: a full word costs 4 byte-accept cycles + WR + WAIT = 6 cycles minimum. Stalls on s_valid=0 simply hold state.
- cpu_rst falls, and boot_done rises, on the edge that enters DONE: the cycle after the last sram_i_ready, or the cycle after the 4th header byte when L==0.
- Reset asserted mid-load: the block returns to HDR at once and any in-flight WR/WAIT write is abandoned. SRAM contents are not cleared. The next boot overwrites from address 0.
- sram_i_ready seen outside WAIT (pre-DONE) is ignored.

## Test plan
- Header 08 00 00 00, payload 11..18 -> SRAM word 0=0x14131211 and word 1=0x18171615, both wstrb=0xF. cpu_rst falls 1 cycle after the second sram_i_ready, boot_done=1.
- Header 05 00 00 00, payload AA BB CC DD EE -> word 0=0xDDCCBBAA with wstrb 0xF, word 1=0x000000EE with wstrb 0x1. Then DONE.
- Header 00 80 00 00 (L=32768=2^15) with SRAM_ADDR_W=15 -> 8192 writes, last at address 0x1FFF, then DONE. Header 01 80 00 00 -> boot_err=1, s_ready=0, cpu_rst stays 1.
- s_valid toggling randomly during load, plus header L=0 -> the image is identical to the no-stall run, and L=0 reaches DONE with no SRAM writes.
- After DONE, cpu_i_valid=1 with cpu_i_addr=1 -> sram_i_valid=1, sram_i_addr=1, sram_i_wstrb=0; cpu_i_ready=1 the next cycle with rdata=word 1. Extra s_valid bytes are not accepted.
- rst pulsed while in WAIT of word 3 -> all outputs return to reset values immediately. A new 4-byte image then writes address 0 correctly.
